// File: rtl/sccb_config_seq.sv
// sccb_config_seq: walks a {reg,value} ROM into the SCCB sender; CFG_DELAY_CMD_EN enables F0 delay commands
module sccb_config_seq #(
  parameter logic [7:0]  CAM_ID     = 8'h42,
  parameter int          ADDR_W     = 8,
  parameter logic [23:0] RESET_WAIT = 24'd1_000_000,
  parameter logic [15:0] DELAY_UNIT = 16'd50_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resend,
  input  logic              taken,
  output logic              send,
  output logic [7:0]        id,
  output logic [7:0]        regis,
  output logic [7:0]        value,
  output logic              done,
  output logic [ADDR_W-1:0] cfg_addr
);
  typedef enum logic [1:0] {FETCH, SEND, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0] regis_n, value_n;
  logic [15:0] rom;
`ifdef CFG_DELAY_CMD_EN
  logic [7:0] ticks;
  logic [23:0] dly;
  assign ticks = rom[7:0] == 8'd0 ? 8'd1 : rom[7:0];
  assign dly = 24'(ticks) * 24'(DELAY_UNIT) - 24'd1;
`endif
  assign id = CAM_ID;
  assign send = state == SEND;
  assign done = state == DONE;
  // configuration table, combinational on the current address
  always_comb begin
    rom = 16'hFFFF;
    case (32'(cfg_addr))
      0: rom = 16'h1280;
      1: rom = 16'h1204;
      2: rom = 16'h1180;
`ifdef CFG_DELAY_CMD_EN
      3: rom = 16'hF003;
      4: rom = 16'h0C00;
      5: rom = 16'h3E00;
      6: rom = 16'h0400;
      7: rom = 16'h40D0;
      8: rom = 16'h3A04;
      9: rom = 16'h1418;
`else
      3: rom = 16'h0C00;
      4: rom = 16'h3E00;
      5: rom = 16'h0400;
      6: rom = 16'h40D0;
      7: rom = 16'h3A04;
      8: rom = 16'h1418;
`endif
      default: rom = 16'hFFFF;
    endcase
  end
  // next state: fetch, hand to sender, settle after soft reset; resend overrides everything
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = cfg_addr;
    regis_n = regis;
    value_n = value;
    case (state)
      FETCH: begin
        regis_n = rom[15:8];
        value_n = rom[7:0];
        state_n = rom == 16'hFFFF ? DONE : SEND;
`ifdef CFG_DELAY_CMD_EN
        if (rom[15:8] == 8'hF0) begin
          state_n = WAIT;
          cnt_n = dly;
          addr_n = cfg_addr + 1'b1;
        end
`endif
      end
      SEND: if (taken) begin
        addr_n = cfg_addr + 1'b1;
        state_n = regis == 8'h12 && value[7] ? WAIT : FETCH;
        cnt_n = regis == 8'h12 && value[7] ? RESET_WAIT - 24'd1 : cnt;
      end
      WAIT: begin
        state_n = cnt == 24'd0 ? FETCH : WAIT;
        cnt_n = cnt == 24'd0 ? cnt : cnt - 24'd1;
      end
      default: ;
    endcase
    if (resend) begin
      state_n = FETCH;
      cnt_n = '0;
      addr_n = '0;
    end
  end
  // state and command registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      cnt <= '0;
      cfg_addr <= '0;
      regis <= '0;
      value <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cfg_addr <= addr_n;
      regis <= regis_n;
      value <= value_n;
    end
endmodule

// File: tb/tb_sccb_config_seq.sv
// tb_sccb_config_seq: randomized taken latency and spurious pulses against a table-walk reference model
module tb_sccb_config_seq;
  localparam logic [7:0] CAM_ID = 8'h42;
  localparam int RESET_WAIT = 16;
  localparam int DELAY_UNIT = 4;
  logic clk = 0, rst_n = 0, resend = 0, taken = 0;
  logic send, done;
  logic [7:0] id, regis, value, cfg_addr;
  logic [15:0] tbl [256];
  logic [7:0] exp_addr;
  int pre, checks, errors;
  bit fin;

  sccb_config_seq #(.CAM_ID(CAM_ID), .ADDR_W(8), .RESET_WAIT(24'(RESET_WAIT)), .DELAY_UNIT(16'(DELAY_UNIT))) dut (
    .clk(clk), .rst_n(rst_n), .resend(resend), .taken(taken), .send(send),
    .id(id), .regis(regis), .value(value), .done(done), .cfg_addr(cfg_addr));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // samples from the fetch of exp_addr until send or done shows, skipping delay entries
  function automatic int lead();
    int t = 1;
`ifdef CFG_DELAY_CMD_EN
    while (tbl[exp_addr][15:8] == 8'hF0) begin
      t += ((tbl[exp_addr][7:0] == 8'd0) ? 1 : int'(tbl[exp_addr][7:0])) * DELAY_UNIT + 1;
      exp_addr++;
    end
`endif
    return t;
  endfunction

  task automatic run_gap(input int wait_cycles);
    int n;
    n = wait_cycles + lead();
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      check("gap_idle", {send, done}, 2'b00);
      taken = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    taken = 0;
    if (tbl[exp_addr] == 16'hFFFF) begin
      check("done_reached", {send, done}, 2'b01);
      check("done_addr", cfg_addr, exp_addr);
      fin = 1;
    end else check("send_rise", {send, done}, 2'b10);
  endtask

  task automatic present(input int lat, input bit rs);
    logic [15:0] w;
    w = tbl[exp_addr];
    check("cmd_regis", regis, w[15:8]);
    check("cmd_value", value, w[7:0]);
    check("cmd_addr", cfg_addr, exp_addr);
    check("id", id, CAM_ID);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("stall_send", send, 1);
      check("stall_cmd", {regis, value}, w);
      check("stall_addr", cfg_addr, exp_addr);
    end
    taken = 1;
    resend = rs;
    @(negedge clk);
    taken = 0;
    resend = 0;
    check("send_drop", send, 0);
    if (rs) begin
      check("rs_taken_addr", cfg_addr, 0);
      check("rs_taken_done", done, 0);
      exp_addr = 0;
      pre = 0;
    end else begin
      exp_addr++;
      check("addr_inc", cfg_addr, exp_addr);
      pre = (w[15:8] == 8'h12 && w[7]) ? RESET_WAIT : 0;
    end
  endtask

  task automatic run_to_done();
    while (!fin) begin
      present($urandom_range(0, 6), 0);
      run_gap(pre);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (tbl[i]) tbl[i] = 16'hFFFF;
`ifdef CFG_DELAY_CMD_EN
    tbl[0:9] = '{16'h1280, 16'h1204, 16'h1180, 16'hF003, 16'h0C00, 16'h3E00, 16'h0400, 16'h40D0, 16'h3A04, 16'h1418};
`else
    tbl[0:8] = '{16'h1280, 16'h1204, 16'h1180, 16'h0C00, 16'h3E00, 16'h0400, 16'h40D0, 16'h3A04, 16'h1418};
`endif
    repeat (3) @(negedge clk);
    check("rst_send", send, 0);
    check("rst_done", done, 0);
    check("rst_addr", cfg_addr, 0);
    check("rst_cmd", {regis, value}, 16'h0000);
    check("rst_id", id, CAM_ID);
    rst_n = 1;
    exp_addr = 0;
    fin = 0;
    run_gap(0);
    while (!fin) begin
      present(exp_addr == 2 ? 100 : $urandom_range(0, 6), 0);
      run_gap(pre);
    end
    for (int i = 0; i < 10; i++) begin
      taken = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("done_hold", done, 1);
      check("done_addr_hold", cfg_addr, exp_addr);
    end
    taken = 0;
    resend = 1;
    @(negedge clk);
    resend = 0;
    check("rs_done_addr", cfg_addr, 0);
    check("rs_done_flags", {send, done}, 2'b00);
    exp_addr = 0;
    fin = 0;
    run_gap(0);
    present(3, 0);
    for (int i = 0; i < 5; i++) begin
      taken = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("wait_idle", {send, done}, 2'b00);
      check("wait_addr", cfg_addr, 1);
    end
    taken = 0;
    resend = 1;
    @(negedge clk);
    resend = 0;
    check("rs_wait_addr", cfg_addr, 0);
    check("rs_wait_flags", {send, done}, 2'b00);
    exp_addr = 0;
    run_gap(0);
    check("reissue", {regis, value}, 16'h1280);
    while (exp_addr != 4) begin
      present($urandom_range(0, 6), 0);
      run_gap(pre);
    end
    present(2, 1);
    run_gap(0);
    run_to_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
